// File: rtl/p88_pkg.sv
// ---------------------------------------------------------------------------
// p88_pkg
// Shared P88 stream format constants and the dumper state type. The P88
// loader imports the same package, so both ends agree on the record
// opcodes and record lengths.
//
// Contents:
//    P88_SECTION  - opcode of the section record (C8)
//    P88_ENTRY    - opcode of the entry record (CA)
//    P88_HDR_LEN  - number of bytes in a section header
//    P88_TRL_LEN  - number of bytes in an entry record
//    p88_state_e  - dumper FSM states
// ---------------------------------------------------------------------------
package p88_pkg;

   localparam logic [7:0] P88_SECTION = 8'hC8;
   localparam logic [7:0] P88_ENTRY   = 8'hCA;

   localparam int P88_HDR_LEN = 9;
   localparam int P88_TRL_LEN = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_RD,
      ST_CAP,
      ST_DATA,
      ST_TRL,
      ST_FIN
   } p88_state_e;

endpackage

// File: rtl/p88_hdr_mux.sv
// ---------------------------------------------------------------------------
// p88_hdr_mux
// Purely combinational selection of the header/trailer byte that goes out
// on the stream, chosen by the byte index and the fields latched at start.
//
// Ports:
//    trailer_i     1   select the entry record (1) or section header (0)
//    idx_i         4   byte index inside the selected record
//    seg_i        16   latched section segment
//    off_i        16   latched section offset
//    len_i        16   latched section byte count
//    entrySeg_i   16   latched entry segment
//    entryOff_i   16   latched entry offset
//    byte_o        8   selected stream byte
// ---------------------------------------------------------------------------
module p88_hdr_mux
   import p88_pkg::*;
(
   input  logic        trailer_i,
   input  logic [3:0]  idx_i,
   input  logic [15:0] seg_i,
   input  logic [15:0] off_i,
   input  logic [15:0] len_i,
   input  logic [15:0] entrySeg_i,
   input  logic [15:0] entryOff_i,
   output logic [7:0]  byte_o
);

   // All multi-byte fields go out little-endian. The two zero bytes at
   // index 5 and 6 of the section header are skip bytes the loader ignores.
   always_comb begin
      byte_o = 8'h00;
      if (trailer_i) begin
         case (idx_i)
            4'd0:    byte_o = P88_ENTRY;
            4'd1:    byte_o = entrySeg_i[7:0];
            4'd2:    byte_o = entrySeg_i[15:8];
            4'd3:    byte_o = entryOff_i[7:0];
            4'd4:    byte_o = entryOff_i[15:8];
            default: byte_o = 8'h00;
         endcase
      end else begin
         case (idx_i)
            4'd0:    byte_o = P88_SECTION;
            4'd1:    byte_o = seg_i[7:0];
            4'd2:    byte_o = seg_i[15:8];
            4'd3:    byte_o = off_i[7:0];
            4'd4:    byte_o = off_i[15:8];
            4'd7:    byte_o = len_i[7:0];
            4'd8:    byte_o = len_i[15:8];
            default: byte_o = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/p88_dumper.sv
// ---------------------------------------------------------------------------
// p88_dumper
// Serialises a region of DRAM into a P88 byte stream: a C8 section record
// (skipped when the length is zero) followed, when P88_DUMP_ENTRY_EN is
// defined, by a CA entry record. Owns the DRAM port only while busy.
//
// Configuration macro: P88_DUMP_ENTRY_EN (append the CA entry record).
//
// Ports:
//    clk_sys      in   1       system clock, rising edge
//    reset_n      in   1       asynchronous active-low reset
//    start        in   1       dump request, honoured only when idle
//    dump_seg     in   16      section segment
//    dump_off     in   16      section offset
//    dump_len     in   16      section byte count
//    entry_seg    in   16      entry segment (CA record)
//    entry_off    in   16      entry offset (CA record)
//    busy         out  1       dump in progress
//    done         out  1       one-cycle completion pulse
//    mem_addr     out  ADDR_W  DRAM read address
//    mem_rd       out  1       DRAM read strobe
//    mem_dout     in   8       DRAM read data, one cycle after mem_rd
//    byte_data    out  8       stream byte
//    byte_valid   out  1       stream valid
//    byte_ready   in   1       stream ready
// ---------------------------------------------------------------------------
module p88_dumper
   import p88_pkg::*;
#(
   parameter int ADDR_W = 18,
   parameter int LEN_W  = 16
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              start,
   input  logic [15:0]       dump_seg,
   input  logic [15:0]       dump_off,
   input  logic [15:0]       dump_len,
   input  logic [15:0]       entry_seg,
   input  logic [15:0]       entry_off,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_dout,
   output logic [7:0]        byte_data,
   output logic              byte_valid,
   input  logic              byte_ready
);

   p88_state_e        state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [15:0]       seg_q, seg_d;
   logic [15:0]       off_q, off_d;
   logic [15:0]       len_q, len_d;
   logic [LEN_W-1:0]  remain_q, remain_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic              finHold_q, finHold_d;
   logic [15:0]       entrySegLat, entryOffLat;
   logic [19:0]       phys;
   logic [7:0]        muxByte;
   logic              handshake;

`ifdef P88_DUMP_ENTRY_EN
   logic [15:0] entrySeg_q, entrySeg_d;
   logic [15:0] entryOff_q, entryOff_d;
   assign entrySegLat = entrySeg_q;
   assign entryOffLat = entryOff_q;
`else
   logic unusedEntry;
   assign unusedEntry = ^{entry_seg, entry_off};
   assign entrySegLat = 16'h0000;
   assign entryOffLat = 16'h0000;
`endif

   // Real-mode style physical address; the 20-bit sum wraps naturally and is
   // then truncated (or extended) to the DRAM address width.
   assign phys      = {dump_seg, 4'b0000} + {4'b0000, dump_off};
   assign handshake = byte_valid & byte_ready;

   p88_hdr_mux u_hdrMux (
      .trailer_i  (state_q == ST_TRL),
      .idx_i      (idx_q),
      .seg_i      (seg_q),
      .off_i      (off_q),
      .len_i      (len_q),
      .entrySeg_i (entrySegLat),
      .entryOff_i (entryOffLat),
      .byte_o     (muxByte)
   );

   // Header and trailer bytes come straight from the mux so they can stream
   // one per cycle; data bytes come from the capture register. Both sources
   // are held constant while a byte is stalled, so the stream stays stable.
   assign byte_valid = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_TRL);
   assign byte_data  = ((state_q == ST_HDR) || (state_q == ST_TRL)) ? muxByte : data_q;
   assign mem_rd     = (state_q == ST_RD);
   assign mem_addr   = addr_q;
   assign busy       = (state_q == ST_HDR) || (state_q == ST_RD) || (state_q == ST_CAP) ||
                       (state_q == ST_DATA) || (state_q == ST_TRL) ||
                       ((state_q == ST_FIN) && finHold_q);
   assign done       = (state_q == ST_FIN) && !finHold_q;

   // Next-state logic. The data loop is RD -> CAP -> DATA per byte, which
   // matches the one-cycle DRAM read latency. An empty dump with no entry
   // record parks one extra cycle in FIN (finHold) so done still comes two
   // cycles after start instead of colliding with the first busy cycle.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      seg_d     = seg_q;
      off_d     = off_q;
      len_d     = len_q;
      remain_d  = remain_q;
      addr_d    = addr_q;
      data_d    = data_q;
      finHold_d = finHold_q;
`ifdef P88_DUMP_ENTRY_EN
      entrySeg_d = entrySeg_q;
      entryOff_d = entryOff_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               seg_d    = dump_seg;
               off_d    = dump_off;
               len_d    = dump_len;
               remain_d = LEN_W'(dump_len);
               addr_d   = ADDR_W'(phys);
               idx_d    = 4'd0;
`ifdef P88_DUMP_ENTRY_EN
               entrySeg_d = entry_seg;
               entryOff_d = entry_off;
`endif
               if (dump_len != 16'h0000) begin
                  state_d = ST_HDR;
               end else begin
`ifdef P88_DUMP_ENTRY_EN
                  state_d = ST_TRL;
`else
                  state_d   = ST_FIN;
                  finHold_d = 1'b1;
`endif
               end
            end
         end
         ST_HDR: begin
            if (handshake) begin
               if (idx_q == 4'(P88_HDR_LEN - 1)) begin
                  idx_d   = 4'd0;
                  state_d = ST_RD;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         ST_RD: begin
            state_d = ST_CAP;
         end
         ST_CAP: begin
            data_d  = mem_dout;
            state_d = ST_DATA;
         end
         ST_DATA: begin
            if (handshake) begin
               addr_d   = addr_q + ADDR_W'(1);
               remain_d = remain_q - LEN_W'(1);
               idx_d    = 4'd0;
               if (remain_q == LEN_W'(1)) begin
`ifdef P88_DUMP_ENTRY_EN
                  state_d = ST_TRL;
`else
                  state_d = ST_FIN;
`endif
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_TRL: begin
            if (handshake) begin
               if (idx_q == 4'(P88_TRL_LEN - 1)) begin
                  idx_d   = 4'd0;
                  state_d = ST_FIN;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         ST_FIN: begin
            if (finHold_q) begin
               finHold_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset returns every output to zero
   // because all outputs are decoded from these registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= 4'd0;
         seg_q     <= 16'h0000;
         off_q     <= 16'h0000;
         len_q     <= 16'h0000;
         remain_q  <= '0;
         addr_q    <= '0;
         data_q    <= 8'h00;
         finHold_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         seg_q     <= seg_d;
         off_q     <= off_d;
         len_q     <= len_d;
         remain_q  <= remain_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         finHold_q <= finHold_d;
      end
   end

`ifdef P88_DUMP_ENTRY_EN
   // Entry record fields, captured together with the section fields.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         entrySeg_q <= 16'h0000;
         entryOff_q <= 16'h0000;
      end else begin
         entrySeg_q <= entrySeg_d;
         entryOff_q <= entryOff_d;
      end
   end
`endif

endmodule

// File: tb/tb_p88_dumper.sv
// ---------------------------------------------------------------------------
// tb_p88_dumper
// Self-checking bench for p88_dumper. A reference model builds the ideal
// byte stream and DRAM read address list from the P88 record rules; a
// monitor collects what the DUT actually emits and checks stall stability.
// Honours P88_DUMP_ENTRY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_p88_dumper;

   localparam int ADDR_W = 18;

`ifdef P88_DUMP_ENTRY_EN
   localparam bit ENTRY_EN = 1'b1;
`else
   localparam bit ENTRY_EN = 1'b0;
`endif

   logic              clk_sys;
   logic              reset_n;
   logic              start;
   logic [15:0]       dump_seg;
   logic [15:0]       dump_off;
   logic [15:0]       dump_len;
   logic [15:0]       entry_seg;
   logic [15:0]       entry_off;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_dout;
   logic [7:0]        byte_data;
   logic              byte_valid;
   logic              byte_ready;

   p88_dumper #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .start      (start),
      .dump_seg   (dump_seg),
      .dump_off   (dump_off),
      .dump_len   (dump_len),
      .entry_seg  (entry_seg),
      .entry_off  (entry_off),
      .busy       (busy),
      .done       (done),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_dout   (mem_dout),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready)
   );

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int readyDuty  = 100;
   int lastStartCycle = 0;

   logic [7:0]        dram [0:(1<<ADDR_W)-1];
   logic [7:0]        expQ[$];
   logic [ADDR_W-1:0] expRdQ[$];
   logic [7:0]        gotQ[$];
   logic [ADDR_W-1:0] rdQ[$];
   int                hsCycQ[$];
   int                doneCount = 0;
   int                doneCycle = 0;
   int                lastHsCycle = 0;
   bit                prevStall = 1'b0;
   logic [7:0]        prevData = 8'h00;

   // 100 MHz style clock and a free-running cycle counter.
   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // DRAM model: data is only meaningful one cycle after a read strobe;
   // otherwise junk is driven so mistimed captures show up in the stream.
   always @(posedge clk_sys) begin
      if (mem_rd) mem_dout <= dram[mem_addr];
      else        mem_dout <= 8'($urandom);
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Stream monitor: records handshakes, reads and done pulses, and checks
   // that a stalled byte is still presented unchanged one cycle later.
   always @(negedge clk_sys) begin
      if (!reset_n) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checkOutput("stallValid", 32'(byte_valid), 32'd1);
            checkOutput("stallData", 32'(byte_data), 32'(prevData));
         end
         if (byte_valid && byte_ready) begin
            gotQ.push_back(byte_data);
            hsCycQ.push_back(cyc);
            lastHsCycle = cyc;
         end
         if (mem_rd) rdQ.push_back(mem_addr);
         if (done) begin
            doneCount++;
            doneCycle = cyc;
         end
         prevStall = byte_valid && !byte_ready;
         prevData  = byte_data;
      end
   end

   // Ready driver: a fresh random decision every cycle at the given duty.
   initial begin
      byte_ready = 1'b0;
      forever begin
         @(posedge clk_sys);
         #1;
         byte_ready = ($urandom_range(0, 99) < readyDuty);
      end
   end

   // Reference model of the ideal stream from the P88 record rules.
   task automatic buildExpected(input logic [15:0] seg, input logic [15:0] off,
                                input logic [15:0] len, input logic [15:0] eseg,
                                input logic [15:0] eoff);
      int physInt;
      int a;
      expQ.delete();
      expRdQ.delete();
      physInt = (int'(seg) * 16 + int'(off)) % (1 << 20);
      if (len != 16'h0000) begin
         expQ.push_back(8'hC8);
         expQ.push_back(seg[7:0]);
         expQ.push_back(seg[15:8]);
         expQ.push_back(off[7:0]);
         expQ.push_back(off[15:8]);
         expQ.push_back(8'h00);
         expQ.push_back(8'h00);
         expQ.push_back(len[7:0]);
         expQ.push_back(len[15:8]);
         for (int i = 0; i < int'(len); i++) begin
            a = (physInt + i) % (1 << ADDR_W);
            expRdQ.push_back(ADDR_W'(a));
            expQ.push_back(dram[ADDR_W'(a)]);
         end
      end
      if (ENTRY_EN) begin
         expQ.push_back(8'hCA);
         expQ.push_back(eseg[7:0]);
         expQ.push_back(eseg[15:8]);
         expQ.push_back(eoff[7:0]);
         expQ.push_back(eoff[15:8]);
      end
   endtask

   // Runs one complete dump and compares stream, reads and done timing.
   // restartAt > 0 pulses start again (with unrelated inputs) that many
   // cycles after the real start.
   task automatic applyStimulus(input logic [15:0] seg, input logic [15:0] off,
                                input logic [15:0] len, input logic [15:0] eseg,
                                input logic [15:0] eoff, input int duty,
                                input int restartAt);
      int  bound;
      bit  finished;
      int  n;
      buildExpected(seg, off, len, eseg, eoff);
      gotQ.delete();
      rdQ.delete();
      hsCycQ.delete();
      doneCount = 0;
      readyDuty = duty;
      @(posedge clk_sys);
      #1;
      dump_seg  = seg;
      dump_off  = off;
      dump_len  = len;
      entry_seg = eseg;
      entry_off = eoff;
      start     = 1'b1;
      lastStartCycle = cyc;
      bound    = 40 * (int'(len) + 20);
      finished = 1'b0;
      for (int k = 1; k <= bound; k++) begin
         @(posedge clk_sys);
         #1;
         start = (k == restartAt);
         if (k == restartAt) begin
            dump_seg  = 16'($urandom);
            dump_off  = 16'($urandom);
            dump_len  = 16'($urandom_range(1, 50));
            entry_seg = 16'($urandom);
            entry_off = 16'($urandom);
         end
         @(negedge clk_sys);
         #1;
         if (k == 1) begin
            checkOutput("busyRise", 32'(busy), 32'd1);
            if (duty == 100 && expQ.size() > 0) begin
               checkOutput("firstValid", 32'(byte_valid), 32'd1);
               checkOutput("firstByte", 32'(byte_data), 32'(expQ[0]));
            end
         end
         if (doneCount > 0) begin
            finished = 1'b1;
            break;
         end
      end
      start = 1'b0;
      if (!finished) checkOutput("doneTimeout", 32'd0, 32'd1);
      repeat (2) @(posedge clk_sys);
      #1;
      checkOutput("doneCount", 32'(doneCount), 32'd1);
      checkOutput("busyIdle", 32'(busy), 32'd0);
      checkOutput("streamLen", 32'(gotQ.size()), 32'(expQ.size()));
      n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("byte%0d", i), 32'(gotQ[i]), 32'(expQ[i]));
      checkOutput("readCount", 32'(rdQ.size()), 32'(expRdQ.size()));
      n = (rdQ.size() < expRdQ.size()) ? rdQ.size() : expRdQ.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("readAddr%0d", i), 32'(rdQ[i]), 32'(expRdQ[i]));
      if (expQ.size() > 0)
         checkOutput("doneTiming", 32'(doneCycle), 32'(lastHsCycle + 1));
      else
         checkOutput("doneTiming", 32'(doneCycle), 32'(lastStartCycle + 2));
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "Busy"},  32'(busy),       32'd0);
      checkOutput({tag, "Done"},  32'(done),       32'd0);
      checkOutput({tag, "Valid"}, 32'(byte_valid), 32'd0);
      checkOutput({tag, "Data"},  32'(byte_data),  32'd0);
      checkOutput({tag, "Rd"},    32'(mem_rd),     32'd0);
      checkOutput({tag, "Addr"},  32'(mem_addr),   32'd0);
   endtask

   initial begin
      int  waitCnt;
      bit  reached;
      reset_n   = 1'b0;
      start     = 1'b0;
      dump_seg  = 16'h0000;
      dump_off  = 16'h0000;
      dump_len  = 16'h0000;
      entry_seg = 16'h0000;
      entry_off = 16'h0000;
      mem_dout  = 8'h00;
      for (int i = 0; i < (1 << ADDR_W); i++) dram[i] = 8'($urandom);
      dram[18'h10010] = 8'h11;
      dram[18'h10011] = 8'h22;
      dram[18'h10012] = 8'h33;

      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      #1;
      checkResetOutputs("reset");
      @(posedge clk_sys);
      #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk_sys);

      $display("[TB] basic 3-byte dump");
      applyStimulus(16'h1000, 16'h0010, 16'd3, 16'hBEEF, 16'hF00D, 100, 0);
      if (hsCycQ.size() > 9) begin
         checkOutput("hdrFirstCycle", 32'(hsCycQ[0]), 32'(lastStartCycle + 1));
         checkOutput("dataLatency", 32'(hsCycQ[9]), 32'(lastStartCycle + 12));
      end else begin
         checkOutput("hsCount", 32'(hsCycQ.size()), 32'd10);
      end

      $display("[TB] zero-length dump");
      applyStimulus(16'h1234, 16'h0000, 16'd0, 16'h1234, 16'h5678, 100, 0);

      $display("[TB] 64-byte dump at 30%% ready");
      applyStimulus(16'($urandom), 16'($urandom), 16'd64, 16'($urandom),
                    16'($urandom), 30, 0);

      $display("[TB] address wrap");
      applyStimulus(16'h3FFF, 16'h000E, 16'd4, 16'h0102, 16'h0304, 100, 0);

      $display("[TB] start while busy");
      applyStimulus(16'h2000, 16'h0123, 16'd5, 16'hAAAA, 16'h5555, 100, 5);

      $display("[TB] random dumps");
      for (int t = 0; t < 3; t++)
         applyStimulus(16'($urandom), 16'($urandom), 16'($urandom_range(1, 24)),
                       16'($urandom), 16'($urandom), int'($urandom_range(40, 100)), 0);

      $display("[TB] reset during data stall");
      buildExpected(16'h0800, 16'h0004, 16'd6, 16'h0000, 16'h0000);
      gotQ.delete();
      doneCount = 0;
      readyDuty = 100;
      @(posedge clk_sys);
      #1;
      dump_seg = 16'h0800;
      dump_off = 16'h0004;
      dump_len = 16'd6;
      start    = 1'b1;
      @(posedge clk_sys);
      #1;
      start   = 1'b0;
      reached = 1'b0;
      for (waitCnt = 0; waitCnt < 200; waitCnt++) begin
         @(negedge clk_sys);
         #1;
         if (gotQ.size() >= 11) begin
            reached = 1'b1;
            break;
         end
      end
      checkOutput("reachData2", 32'(reached), 32'd1);
      readyDuty = 0;
      @(negedge clk_sys);
      #1;
      reached = 1'b0;
      for (waitCnt = 0; waitCnt < 20; waitCnt++) begin
         @(negedge clk_sys);
         #1;
         if (byte_valid) begin
            reached = 1'b1;
            break;
         end
      end
      checkOutput("stallData2", 32'(reached), 32'd1);
      checkOutput("stallByte2", 32'(byte_data), 32'(expQ[11]));
      reset_n = 1'b0;
      @(negedge clk_sys);
      #1;
      checkResetOutputs("midReset");
      repeat (3) @(posedge clk_sys);
      #1;
      checkOutput("noDoneOnReset", 32'(doneCount), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk_sys);
      applyStimulus(16'h0800, 16'h0004, 16'd6, 16'h4321, 16'h8765, 100, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
